display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is enabled per scan slot (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_LZ, default 1, where 1 enables leading-zero blanking and 0 shows all four digits.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port value, input, 14, unsigned binary number to display; 0..9999 is legal.
REQ-006 SHALL have port load, input, 1, one-cycle request to convert value.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port overflow, output, 1, high when the last accepted value was greater than 9999.
REQ-009 SHALL have port bch, output, 4, BCD code of the active digit, with 4'hF meaning blank, to drive the downstream 7-segment decoder.
REQ-010 SHALL have port digit_en, output, 4, one-hot active-high digit enable, where bit0 is the ones digit and bit3 is the thousands digit.

Function
REQ-011 SHALL have the FSM states IDLE and CONV; IDLE goes to CONV on load=1; CONV goes to IDLE after the 14th shift.
REQ-012 SHALL, in IDLE on load=1, capture value into a 14-bit shift register, clear a 16-bit BCD scratch register, and set busy=1 from the next cycle.
REQ-013 SHALL, in CONV, do one double-dabble iteration per cycle: add 3 to each scratch nibble that is >=5, then shift {scratch, shift_reg} left by 1.
REQ-014 SHALL keep busy high for exactly 14 cycles; on the edge that ends the 14th iteration, SHALL copy the scratch register into the display digit registers and SHALL drop busy.
REQ-015 SHALL ignore load while busy=1, with no effect on the conversion in progress.
REQ-016 SHALL register overflow at load acceptance as (value > 9999); while overflow=1, the committed digits SHALL all be blank (4'hF) and SHALL NOT depend on the conversion result.
REQ-017 SHALL double-buffer the display digits: during CONV, bch/digit_en continue scanning the previously committed digits.
REQ-018 SHALL run a prescaler that counts 0..REFRESH_DIV-1 and wraps, and SHALL advance the digit index 0->1->2->3->0 on each wrap.
REQ-019 SHALL set digit_en to the one-hot of the digit index, registered, with exactly one bit high at all times after reset.
REQ-020 SHALL set bch to the committed digit at the index, registered, and aligned with digit_en in the same cycle.
REQ-021 SHALL, when BLANK_LZ=1, output 4'hF on digit i (i=3..1) if all committed digits at positions >= i are 0; digit 0 SHALL never be blanked by this rule.
REQ-022 SHALL run the scan independently of the FSM; a commit that coincides with an index advance SHALL show the new digit data from the following cycle.

Reset
REQ-023 SHALL, with rst=1 at a rising edge, set the FSM to IDLE, busy=0, overflow=0, all digit registers to 0, prescaler to 0, index to 0, digit_en=4'b0001, and bch=4'h0.
REQ-024 SHALL, on rst during CONV, abandon the conversion, leave the digits at their reset values, and SHALL NOT commit.
REQ-025 SHALL give rst priority over load in the same cycle.

Verification
REQ-026 SHALL cover reset: after rst, check digit_en=0001, bch=0, busy=0; with REFRESH_DIV=4, digit_en SHALL step to 0010 after 4 cycles and 0001 again after 16 cycles.
REQ-027 SHALL cover basic conversion: load value=1234 -> busy high exactly 14 cycles, then digit_en 0001/0010/0100/1000 SHALL pair with bch 4/3/2/1.
REQ-028 SHALL cover blanking: load value=7 with BLANK_LZ=1 -> bch F,F,F,7 for digits 3..0; value=0 -> F,F,F,0; BLANK_LZ=0 with value=7 -> 0,0,0,7.
REQ-029 SHALL cover overflow: load value=12000 -> overflow=1 and all digits 4'hF; a later load of 9999 -> overflow=0 and digits 9,9,9,9.
REQ-030 SHALL cover load during busy: load 42, then load 5555 on cycle 3 of CONV -> the 5555 load is ignored and the display shows 42 (blanked F,F,4,2).
REQ-031 SHALL cover reset mid-conversion: after 500 is committed, load 8888 and assert rst on cycle 7 -> digits 0, busy=0, and no commit of 8888.

Source files
------------

// File: rtl/display_scanner.sv
// Four-digit multiplexed display driver: a double-dabble binary-to-BCD converter
// feeds double-buffered digit registers that a free-running prescaler scans out.
module display_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  bch,
    output logic [3:0]  digit_en,
    output logic [0:0]  fsm_state_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam int            PW      = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

    logic [0:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [13:0]   shift_q, shift_d;
    logic [15:0]   scratch_q, scratch_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   digits_q, digits_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    digit_en_q, digit_en_d;
    logic [3:0]    bch_q, bch_d;

    logic [15:0]   adj;
    logic [15:0]   disp;

    // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
    always_comb begin
        adj = scratch_q;
        for (int n = 0; n < 4; n++) begin
            if (scratch_q[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        overflow_d = overflow_q;
        digits_d   = digits_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = CONV;
                    cnt_d      = 4'd0;
                    shift_d    = value;
                    scratch_d  = 16'h0000;
                    overflow_d = (value > 14'd9999);
                end
            end
            CONV: begin
                scratch_d = {adj[14:0], shift_q[13]};
                shift_d   = {shift_q[12:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d  = IDLE;
                    digits_d = overflow_q ? 16'hFFFF : {adj[14:0], shift_q[13]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Leading-zero blanking; the ones digit is always shown.
    always_comb begin
        disp = digits_q;
        if (BLANK_LZ) begin
            if (digits_q[15:12] == 4'h0) disp[15:12] = 4'hF;
            if (digits_q[15:8]  == 8'h00) disp[11:8] = 4'hF;
            if (digits_q[15:4]  == 12'h000) disp[7:4] = 4'hF;
        end
    end

    always_comb begin
        pre_d      = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        idx_d      = (pre_q == PRE_MAX) ? idx_q + 2'd1 : idx_q;
        digit_en_d = 4'b0001 << idx_d;
        bch_d      = disp[{idx_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 14'd0;
            scratch_q  <= 16'h0000;
            overflow_q <= 1'b0;
            digits_q   <= 16'h0000;
            pre_q      <= '0;
            idx_q      <= 2'd0;
            digit_en_q <= 4'b0001;
            bch_q      <= 4'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            overflow_q <= overflow_d;
            digits_q   <= digits_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            digit_en_q <= digit_en_d;
            bch_q      <= bch_d;
        end
    end

    assign busy        = (state_q == CONV);
    assign overflow    = overflow_q;
    assign bch         = bch_q;
    assign digit_en    = digit_en_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: two instances (blanking on/off) against a decimal
// arithmetic model, plus table vectors and hand-written corner sequences.
module tb_display_scanner;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        busy, overflow, busy0, overflow0;
    logic [3:0]  bch, digit_en, bch0, digit_en0;
    logic [0:0]  st, st0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    display_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy), .overflow(overflow), .bch(bch), .digit_en(digit_en),
        .fsm_state_o(st)
    );

    display_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy0), .overflow(overflow0), .bch(bch0), .digit_en(digit_en0),
        .fsm_state_o(st0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Decimal digit i of v as it should appear on the display.
    function automatic logic [3:0] mdig(input int v, input bit ovf, input int i, input bit blank);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (ovf) return 4'hF;
        if (blank && i > 0 && v < p) return 4'hF;
        return 4'((v / p) % 10);
    endfunction

    int   tick, left, shown, pend, idx;
    bit   shown_ovf, pend_ovf;
    logic [3:0] e_en, e_bch, e_bch0;
    logic e_busy, e_ovf;

    always @(posedge clk) begin
        if (rst) begin
            tick = 0; left = 0; shown = 0; shown_ovf = 0;
            e_ovf = 0; e_busy = 0; e_en = 4'b0001; e_bch = 4'h0; e_bch0 = 4'h0;
        end else begin
            tick++;
            idx    = (tick / DIV) % 4;
            e_en   = 4'(1 << idx);
            e_bch  = mdig(shown, shown_ovf, idx, 1'b1);
            e_bch0 = mdig(shown, shown_ovf, idx, 1'b0);
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    shown     = pend;
                    shown_ovf = pend_ovf;
                end
            end else if (load) begin
                left     = 14;
                pend     = int'(value);
                pend_ovf = (value > 14'd9999);
                e_ovf    = pend_ovf;
            end
            e_busy = (left > 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_en",    16'(digit_en),  16'(e_en));
            chk("m_bch",   16'(bch),       16'(e_bch));
            chk("m_busy",  16'(busy),      16'(e_busy));
            chk("m_ovf",   16'(overflow),  16'(e_ovf));
            chk("m_en0",   16'(digit_en0), 16'(e_en));
            chk("m_bch0",  16'(bch0),      16'(e_bch0));
        end
    end

    task automatic pulse_load(input int v);
        @(negedge clk);
        value = 14'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40 && busy; n++) @(negedge clk);
        chk("idle_timeout", 16'(busy), 16'h0);
    endtask

    task automatic scan(output logic [15:0] g1, output logic [15:0] g0);
        g1 = 16'hxxxx;
        g0 = 16'hxxxx;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4 * DIV; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (digit_en[i])  g1[4*i +: 4] = bch;
                if (digit_en0[i]) g0[4*i +: 4] = bch0;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int          v;
        logic [15:0] e1;
        logic [15:0] e0;
        bit          ovf;
    } vec_t;

    vec_t tbl[6];
    logic [15:0] g1, g0;
    int n_busy;

    initial begin
        tbl[0] = '{1234,  16'h1234, 16'h1234, 1'b0};
        tbl[1] = '{7,     16'hFFF7, 16'h0007, 1'b0};
        tbl[2] = '{0,     16'hFFF0, 16'h0000, 1'b0};
        tbl[3] = '{12000, 16'hFFFF, 16'hFFFF, 1'b1};
        tbl[4] = '{9999,  16'h9999, 16'h9999, 1'b0};
        tbl[5] = '{500,   16'hF500, 16'h0500, 1'b0};

        rst = 1'b1; load = 1'b0; value = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        chk("rst_en",   16'(digit_en), 16'h0001);
        chk("rst_bch",  16'(bch),      16'h0000);
        chk("rst_busy", 16'(busy),     16'h0000);
        repeat (DIV) @(negedge clk);
        chk("step_en1", 16'(digit_en), 16'h0002);
        repeat (3 * DIV) @(negedge clk);
        chk("wrap_en0", 16'(digit_en), 16'h0001);

        pulse_load(1234);
        n_busy = 0;
        for (int n = 0; n < 40 && busy; n++) begin
            n_busy++;
            @(negedge clk);
        end
        chk("busy_cycles", 16'(n_busy), 16'd14);

        for (int t = 0; t < 6; t++) begin
            pulse_load(tbl[t].v);
            wait_idle();
            chk("tbl_ovf", 16'(overflow), 16'(tbl[t].ovf));
            scan(g1, g0);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("tbl%0d_lz_d%0d", t, i), 16'(g1[4*i +: 4]), 16'(tbl[t].e1[4*i +: 4]));
                chk($sformatf("tbl%0d_nb_d%0d", t, i), 16'(g0[4*i +: 4]), 16'(tbl[t].e0[4*i +: 4]));
            end
        end

        // 8888 started, then reset on the 7th conversion cycle: nothing may commit.
        pulse_load(8888);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 16'(busy), 16'h0);
        scan(g1, g0);
        chk("midrst_lz", g1, 16'hFFF0);
        chk("midrst_nb", g0, 16'h0000);

        // Second load arrives on CONV cycle 3 and must be dropped.
        pulse_load(42);
        @(negedge clk);
        value = 14'd5555;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_idle();
        scan(g1, g0);
        chk("ignore_lz", g1, 16'hFF42);
        chk("ignore_nb", g0, 16'h0042);

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            value = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 3) == 0) value = 14'($urandom_range(0, 120));
            load  = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
